// File: rtl/apb_reg_completer.sv
// APB completer terminating an APB segment and exposing a register bank.
// Register 0 is a read-only ID; the others are read/write from APB.
//
// Ports:
//   PCLK, PRESETn          clock, synchronous active-low reset
//   PSEL, PENABLE, PWRITE  APB control
//   PADDR, PWDATA          APB byte address and write data
//   PSTRB                  byte strobes (only with APB_PSTRB_EN defined)
//   PRDATA, PREADY,        APB response; PRDATA/PSLVERR are zero
//   PSLVERR                whenever PREADY is low
//   regs_o                 flattened registers, slice i = register i
//   wr_pulse_o             one-cycle pulse per committed register write
//
// Optional feature macro: APB_PSTRB_EN (byte-strobed writes).
module apb_reg_completer #(
    parameter int          ADDR_WIDTH  = 13,
    parameter int          DATA_WIDTH  = 32,
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic                           PCLK,
    input  logic                           PRESETn,
    input  logic                           PSEL,
    input  logic                           PENABLE,
    input  logic                           PWRITE,
    input  logic [ADDR_WIDTH-1:0]          PADDR,
    input  logic [DATA_WIDTH-1:0]          PWDATA,
`ifdef APB_PSTRB_EN
    input  logic [DATA_WIDTH/8-1:0]        PSTRB,
`endif
    output logic [DATA_WIDTH-1:0]          PRDATA,
    output logic                           PREADY,
    output logic                           PSLVERR,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]            wr_pulse_o
);

    localparam int NB  = DATA_WIDTH / 8;
    localparam int OFF = $clog2(NB);
    localparam int IW  = ADDR_WIDTH - OFF;
    localparam int RIW = $clog2(NUM_REGS);

    localparam logic [DATA_WIDTH-1:0] ID_WORD = ID_VALUE[DATA_WIDTH-1:0];

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic                  wr_q;
    logic                  err_q;
    logic [RIW-1:0]        idx_q;
    logic [DATA_WIDTH-1:0] rdat_q;
    logic [NB-1:0]         strb_q;

    logic [DATA_WIDTH-1:0] regs [1:NUM_REGS-1];

    // Setup-phase decode
    logic [IW-1:0]         idx_in;
    logic                  in_range;
    logic                  set_err;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] set_rdat;
    logic [NB-1:0]         strb_in;

    // Completion-phase write path
    logic [DATA_WIDTH-1:0] wmask;
    logic                  commit;

    assign idx_in   = PADDR[ADDR_WIDTH-1:OFF];
    assign in_range = idx_in < IW'(NUM_REGS);
    assign set_err  = !in_range || (PWRITE && idx_in == '0);

`ifdef APB_PSTRB_EN
    assign strb_in = PSTRB;
`else
    assign strb_in = '1;
`endif

    // Byte-offset address bits carry no information for word registers.
    if (OFF > 0) begin : g_off
        logic unused_off;
        assign unused_off = ^PADDR[OFF-1:0];
    end

    always_comb begin
        rd_word = ID_WORD;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (idx_in == IW'(i)) begin
                rd_word = regs[i];
            end
        end
    end

    // Read data is captured at setup; errors and writes return zero.
    assign set_rdat = (PWRITE || set_err) ? '0 : rd_word;

    always_comb begin
        wmask = '0;
        for (int b = 0; b < NB; b++) begin
            wmask[8*b +: 8] = {8{strb_q[b]}};
        end
    end

    // An all-zero strobe write completes cleanly but changes nothing.
    assign commit = wr_q && !err_q && (|strb_q);

    always_comb begin
        regs_o = '0;
        regs_o[DATA_WIDTH-1:0] = ID_WORD;
        for (int i = 1; i < NUM_REGS; i++) begin
            regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state      <= S_IDLE;
            cnt        <= '0;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
            idx_q      <= '0;
            rdat_q     <= '0;
            strb_q     <= '0;
            PREADY     <= 1'b0;
            PSLVERR    <= 1'b0;
            PRDATA     <= '0;
            wr_pulse_o <= '0;
            for (int i = 1; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            wr_pulse_o <= '0;
            unique case (state)
                S_IDLE: begin
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                    PRDATA  <= '0;
                    // PENABLE without a preceding setup is ignored here.
                    if (PSEL && !PENABLE) begin
                        wr_q   <= PWRITE;
                        err_q  <= set_err;
                        idx_q  <= idx_in[RIW-1:0];
                        rdat_q <= set_rdat;
                        strb_q <= strb_in;
                        cnt    <= 4'(WAIT_STATES);
                        // Zero wait states: respond in the first access
                        // cycle, so the response is registered at setup.
                        if (WAIT_STATES == 0) begin
                            state   <= S_RESP;
                            PREADY  <= 1'b1;
                            PSLVERR <= set_err;
                            PRDATA  <= set_rdat;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!PSEL) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                        // Counter hits zero at this edge: next cycle
                        // is the completion cycle.
                        if (cnt == 4'd1) begin
                            state   <= S_RESP;
                            PREADY  <= 1'b1;
                            PSLVERR <= err_q;
                            PRDATA  <= rdat_q;
                        end
                    end
                end
                S_RESP: begin
                    state   <= S_IDLE;
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                    PRDATA  <= '0;
                    if (commit) begin
                        for (int i = 1; i < NUM_REGS; i++) begin
                            if (idx_q == RIW'(i)) begin
                                regs[i] <= (regs[i] & ~wmask)
                                         | (PWDATA & wmask);
                                wr_pulse_o[i] <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
